// File: rtl/restoring_divider_seq.sv
//==============================================================================
// Module      : restoring_divider_seq
// Description : Multi-cycle restoring divider, one quotient bit per clock,
//               start/busy/done handshake. DIV_SIGNED_EN selects signed mode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module restoring_divider_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int                 c_CNT_W   = $clog2(WIDTH) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic [WIDTH-1:0]   r_quotient;
   logic [WIDTH-1:0]   r_remainder;
   logic               r_dbz;

   logic [WIDTH:0]     w_part;
   logic [WIDTH+1:0]   w_trial;
   logic               w_borrow;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_quo_next;
   logic [WIDTH-1:0]   w_dvd_mag;
   logic [WIDTH-1:0]   w_dvs_mag;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   // Partial remainder keeps the bit shifted out of R, so 2R+1 never truncates.
   always_comb begin
      w_part     = {r_rem, r_quo[WIDTH-1]};
      w_trial    = {1'b0, w_part} - {2'b00, r_div};
      w_borrow   = w_trial[WIDTH+1];
      w_rem_next = w_borrow ? w_part[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_quo_next = {r_quo[WIDTH-2:0], ~w_borrow};
   end

`ifdef DIV_SIGNED_EN
   logic r_neg_q;
   logic r_neg_r;

   // Magnitude of the most-negative value is 2^(WIDTH-1), representable unsigned.
   always_comb begin
      w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
      w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
      w_quo_fix = r_neg_q ? -w_quo_next : w_quo_next;
      w_rem_fix = r_neg_r ? -w_rem_next : w_rem_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == c_ST_IDLE && start) begin
         r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_neg_r <= dividend[WIDTH-1];
      end
   end
`else
   always_comb begin
      w_dvd_mag = dividend;
      w_dvs_mag = divisor;
      w_quo_fix = w_quo_next;
      w_rem_fix = w_rem_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (start) begin
                  r_rem <= '0;
                  r_quo <= w_dvd_mag;
                  r_div <= w_dvs_mag;
                  r_cnt <= '0;
                  if (divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_dbz       <= 1'b1;
                     r_state     <= c_ST_DONE;
                  end else begin
                     r_dbz   <= 1'b0;
                     r_state <= c_ST_RUN;
                  end
               end
            end
            c_ST_RUN: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt + c_CNT_ONE;
               if (r_cnt == c_LAST) begin
                  r_quotient  <= w_quo_fix;
                  r_remainder <= w_rem_fix;
                  r_state     <= c_ST_DONE;
               end
            end
            c_ST_DONE: r_state <= c_ST_IDLE;
            default:   r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign busy        = (r_state != c_ST_IDLE);
   assign done        = (r_state == c_ST_DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_seq.sv
//==============================================================================
// Module      : tb_restoring_divider_seq
// Description : Self-checking bench for restoring_divider_seq (WIDTH=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_restoring_divider_seq;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks = 0;
   int failures = 0;

   restoring_divider_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic       dbz;
      int         lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Independent reference: truncating division, zero-divisor convention.
   task automatic model(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r);
      int sa, sb;
      if (b == 4'd0) begin
         q = 4'hF;
         r = a;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = {{28{a[3]}}, a};
         sb = {{28{b[3]}}, b};
`else
         sa = {28'd0, a};
         sb = {28'd0, b};
`endif
         q = 4'(sa / sb);
         r = 4'(sa % sb);
      end
   endtask

   // Issues one division from IDLE; returns results and cycles from capture to done.
   task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] q, output logic [3:0] r,
                          output logic dbz, output int lat);
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = ~a;
      divisor = ~b;
      chk("busy_after_capture", int'(busy), 1);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      q = quotient;
      r = remainder;
      dbz = div_by_zero;
      @(posedge clk); #1;
      chk("done_pulse_width", int'(done), 0);
      chk("busy_back_idle", int'(busy), 0);
      chk("result_held", int'({dbz, q, r}), int'({div_by_zero, quotient, remainder}));
   endtask

   initial begin
      logic [3:0] q, r, eq, er;
      logic       dbz;
      int         lat, ndone;

`ifdef DIV_SIGNED_EN
      vecs[0] = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 4};
      vecs[1] = '{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 4};
      vecs[2] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 4};
      vecs[3] = '{4'b0111, 4'b0000, 4'b1111, 4'b0111, 1'b1, 0};
      vecs[4] = '{4'b1101, 4'b0100, 4'b0000, 4'b1101, 1'b0, 4};
      vecs[5] = '{4'b0101, 4'b0011, 4'b0001, 4'b0010, 1'b0, 4};
      vecs[6] = '{4'b1011, 4'b0011, 4'b1111, 4'b1110, 1'b0, 4};
      vecs[7] = '{4'b0101, 4'b1101, 4'b1111, 4'b0010, 1'b0, 4};
      vecs[8] = '{4'b1011, 4'b1101, 4'b0001, 4'b1110, 1'b0, 4};
      vecs[9] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b1, 0};
`else
      vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 4};
      vecs[1] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1, 0};
      vecs[2] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 4};
      vecs[3] = '{4'd3,  4'd5,  4'd0,  4'd3,  1'b0, 4};
      vecs[4] = '{4'd9,  4'd2,  4'd4,  4'd1,  1'b0, 4};
      vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 4};
      vecs[6] = '{4'd14, 4'd15, 4'd0,  4'd14, 1'b0, 4};
      vecs[7] = '{4'd0,  4'd3,  4'd0,  4'd0,  1'b0, 4};
      vecs[8] = '{4'd15, 4'd7,  4'd2,  4'd1,  1'b0, 4};
      vecs[9] = '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1, 0};
`endif

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      chk("reset_dbz", int'(div_by_zero), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].a, vecs[i].b, q, r, dbz, lat);
         chk($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].q));
         chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
         chk($sformatf("vec%0d_dbz", i), int'(dbz), int'(vecs[i].dbz));
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      end

      // Back-to-back with start held high; operands change right after capture
      start = 1'b1;
      dividend = 4'd15;
      divisor = 4'd1;
      @(posedge clk); #1;
      dividend = 4'd3;
      divisor = 4'd5;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      model(4'd15, 4'd1, eq, er);
      chk("b2b_first_latency", lat, 4);
      chk("b2b_first_result", int'({quotient, remainder}), int'({eq, er}));
      @(posedge clk); #1;
      chk("b2b_done_to_idle", int'({busy, done}), 0);
      @(posedge clk); #1;
      chk("b2b_second_capture", int'(busy), 1);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      model(4'd3, 4'd5, eq, er);
      chk("b2b_second_latency", lat, 4);
      chk("b2b_second_result", int'({quotient, remainder, div_by_zero}), int'({eq, er, 1'b0}));
      @(posedge clk); #1;

      // Reset in RUN after two iterations, preceded by a nonzero result
      run_div(4'd13, 4'd4, q, r, dbz, lat);
      start = 1'b1;
      dividend = 4'd9;
      divisor = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrun_reset_outputs",
          int'({busy, done, quotient, remainder, div_by_zero}), 0);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("midrun_reset_no_done", ndone, 0);
      run_div(4'd9, 4'd2, q, r, dbz, lat);
      model(4'd9, 4'd2, eq, er);
      chk("after_reset_result", int'({q, r, dbz}), int'({eq, er, 1'b0}));

      // Exhaustive sweep against the reference model
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_div(4'(a), 4'(b), q, r, dbz, lat);
            model(4'(a), 4'(b), eq, er);
            chk($sformatf("sweep_%0d_%0d", a, b), int'({dbz, q, r}),
                int'({(b == 0), eq, er}));
            chk($sformatf("sweep_lat_%0d_%0d", a, b), lat, (b == 0) ? 0 : 4);
`ifndef DIV_SIGNED_EN
            if (b != 0) begin
               chk($sformatf("invariant_%0d_%0d", a, b),
                   int'(q) * b + int'(r) + ((int'(r) < b) ? 0 : 1000), a);
            end
`endif
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
